float_add_seq: RTL and testbench

FLOAT_ADD_SEQ -- requirements
Module: float_add_seq

---
 rtl/float_add_seq_if.sv | 26 ++
 rtl/float_add_seq.sv | 166 ++++++++++++++++
 tb/tb_float_add_seq.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_add_seq_if.sv
// Request/result bundle for the sequential floating-point adder.
//
// Handshake: the master raises req with a, b and sub stable; the slave takes
// them on the first rising edge where it is idle (busy low) and ignores req at
// every other time, so no request is ever queued. busy stays high from the
// cycle after acceptance through the completion cycle. ack is a one-cycle pulse
// in that completion cycle; out/overflow become valid with ack and hold until
// the next ack.
interface float_add_seq_if #(
  parameter int float_exp_width  = 8,
  parameter int float_mant_width = 23
);
  localparam int float_width = 1 + float_exp_width + float_mant_width;

  logic                   req;
  logic                   sub;
  logic [float_width-1:0] a;
  logic [float_width-1:0] b;
  logic                   busy;
  logic                   ack;
  logic [float_width-1:0] out;
  logic                   overflow;

  modport master (output req, sub, a, b, input busy, ack, out, overflow);
  modport slave  (input req, sub, a, b, output busy, ack, out, overflow);
endinterface

// File: rtl/float_add_seq.sv
// Multi-cycle floating-point adder/subtractor: IDLE -> ALIGN -> ADD -> NORM
// (one step per cycle) -> DONE. No denormals, no rounding (truncation), and
// results that reach the all-ones exponent through a carry saturate.
module float_add_seq #(
  parameter int float_exp_width  = 8,
  parameter int float_mant_width = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  float_add_seq_if.slave       bus,
  output logic [2:0]           o_dbg_state
);
  localparam int EW = float_exp_width;
  localparam int MW = float_mant_width;
  localparam int FW = 1 + EW + MW;
  localparam int IW = MW + 2;  // {carry, hidden, mant}

  localparam logic [EW:0] EXP_ONES = {1'b0, {EW{1'b1}}};
  localparam logic [EW:0] EXP_ONE  = (EW+1)'(1);
  localparam logic [EW:0] SHIFT_LIM = (EW+1)'(IW);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t        r_state;
  logic          r_sign_a, r_sign_b, r_sign;
  logic [EW-1:0] r_exp_a, r_exp_b;
  logic [IW-1:0] r_man_a, r_man_b, r_man;
  logic [EW:0]   r_exp;   // one spare bit so a carry out of all-ones is seen
  logic          r_ovf;   // ADD carried into the all-ones exponent
  logic          r_busy, r_ack, r_overflow;
  logic [FW-1:0] r_out;

  // Operand decode at capture: exp==0 means exact zero.
  logic [EW-1:0] w_a_exp, w_b_exp;
  logic [IW-1:0] w_a_int, w_b_int;
  assign w_a_exp = bus.a[FW-2 -: EW];
  assign w_b_exp = bus.b[FW-2 -: EW];
  assign w_a_int = (w_a_exp == '0) ? '0 : {1'b0, 1'b1, bus.a[MW-1:0]};
  assign w_b_int = (w_b_exp == '0) ? '0 : {1'b0, 1'b1, bus.b[MW-1:0]};

  // Alignment: shift the smaller-exponent mantissa right, truncating.
  logic          w_a_ge;
  logic [EW-1:0] w_diff;
  logic [IW-1:0] w_small, w_shifted;
  assign w_a_ge    = (r_exp_a >= r_exp_b);
  assign w_diff    = w_a_ge ? (r_exp_a - r_exp_b) : (r_exp_b - r_exp_a);
  assign w_small   = w_a_ge ? r_man_b : r_man_a;
  assign w_shifted = ({1'b0, w_diff} >= SHIFT_LIM) ? '0 : (w_small >> w_diff);

  // Signed-magnitude add; the sum of two IW-bit mantissas with a clear top
  // bit cannot exceed IW bits.
  logic          w_same, w_a_gt, w_res_sign, w_carry;
  logic [IW-1:0] w_sum, w_dif, w_mag;
  logic [EW:0]   w_exp_inc;
  assign w_same     = (r_sign_a == r_sign_b);
  assign w_a_gt     = (r_man_a > r_man_b);
  assign w_sum      = r_man_a + r_man_b;
  assign w_dif      = w_a_gt ? (r_man_a - r_man_b) : (r_man_b - r_man_a);
  assign w_mag      = w_same ? w_sum : w_dif;
  assign w_res_sign = w_same ? r_sign_a :
                      (w_mag == '0) ? 1'b0 :
                      (w_a_gt ? r_sign_a : r_sign_b);
  assign w_carry    = w_mag[IW-1];
  assign w_exp_inc  = r_exp + EXP_ONE;

  // Sequencer and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_out      <= '0;
      r_overflow <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_sign     <= 1'b0;
      r_exp_a    <= '0;
      r_exp_b    <= '0;
      r_man_a    <= '0;
      r_man_b    <= '0;
      r_man      <= '0;
      r_exp      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_sign_a <= bus.a[FW-1];
            r_sign_b <= bus.b[FW-1] ^ bus.sub;
            r_exp_a  <= w_a_exp;
            r_exp_b  <= w_b_exp;
            r_man_a  <= w_a_int;
            r_man_b  <= w_b_int;
            r_busy   <= 1'b1;
            r_state  <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (w_a_ge) begin
            r_man_b <= w_shifted;
            r_exp   <= {1'b0, r_exp_a};
          end else begin
            r_man_a <= w_shifted;
            r_exp   <= {1'b0, r_exp_b};
          end
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_sign <= w_res_sign;
          if (w_carry) begin
            r_man <= w_mag >> 1;
            r_exp <= w_exp_inc;
            r_ovf <= (w_exp_inc >= EXP_ONES);
          end else begin
            r_man <= w_mag;
            r_ovf <= 1'b0;
          end
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_ovf) begin
            r_out      <= {r_sign, {EW{1'b1}}, {MW{1'b0}}};
            r_overflow <= 1'b1;
            r_ack      <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_man == '0) begin
            r_out      <= '0;
            r_overflow <= 1'b0;
            r_ack      <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_man[MW]) begin
            r_out      <= {r_sign, r_exp[EW-1:0], r_man[MW-1:0]};
            r_overflow <= 1'b0;
            r_ack      <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_exp == EXP_ONE) begin
            // Would need a denormal: flush to +0.
            r_out      <= '0;
            r_overflow <= 1'b0;
            r_ack      <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_man <= r_man << 1;
            r_exp <= r_exp - EXP_ONE;
          end
        end
        S_DONE: begin
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.ack      = r_ack;
  assign bus.out      = r_out;
  assign bus.overflow = r_overflow;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_float_add_seq.sv
// Bench for float_add_seq: an integer-arithmetic model predicts result,
// overflow and ack latency; a negedge monitor checks every cycle.
module tb_float_add_seq;
  localparam int EW = 8;
  localparam int MW = 23;
  localparam int FW = 1 + EW + MW;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  float_add_seq_if #(.float_exp_width(EW), .float_mant_width(MW)) bus_if ();

  float_add_seq #(.float_exp_width(EW), .float_mant_width(MW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int                n_vec = 0;
  int                n_err = 0;
  logic [FW:0]       exp_q[$];   // {overflow, out}
  int                lat_q[$];
  bit                mon_en = 1'b0;
  bit                outstanding = 1'b0;
  int                cyc = 0;
  logic [FW-1:0]     last_out = '0;
  logic              last_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Exact value arithmetic on integers: decode, align with truncation, signed
  // add, then normalise by locating the leading one.
  function automatic void model(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                input logic s, output logic [FW-1:0] res,
                                output logic ovf, output int k);
    longint ma, mb, va, vb, sum, mag;
    int     ea, eb, e, d, p, sh;
    logic   sa, sb, sg;
    sa = a[FW-1];
    sb = b[FW-1] ^ s;
    ea = int'(a[FW-2 -: EW]);
    eb = int'(b[FW-2 -: EW]);
    ma = (ea == 0) ? 0 : ((longint'(1) << MW) | longint'(a[MW-1:0]));
    mb = (eb == 0) ? 0 : ((longint'(1) << MW) | longint'(b[MW-1:0]));
    if (ea >= eb) begin
      e = ea; d = ea - eb;
      mb = (d >= MW + 2) ? 0 : (mb >> d);
    end else begin
      e = eb; d = eb - ea;
      ma = (d >= MW + 2) ? 0 : (ma >> d);
    end
    va  = sa ? -ma : ma;
    vb  = sb ? -mb : mb;
    sum = va + vb;
    sg  = (sum < 0);
    mag = sg ? -sum : sum;
    ovf = 1'b0;
    k   = 0;
    res = '0;
    if (mag == 0) return;
    if (mag >= (longint'(1) << (MW + 1))) begin
      mag = mag >> 1;
      e   = e + 1;
      if (e >= (1 << EW) - 1) begin
        res = {sg, {EW{1'b1}}, {MW{1'b0}}};
        ovf = 1'b1;
        return;
      end
    end
    p = 0;
    for (int i = 0; i <= MW + 1; i++) if (mag[i]) p = i;
    sh = MW - p;
    if (e - sh >= 1) begin
      k   = sh;
      mag = mag << sh;
      res = {sg, EW'(e - sh), MW'(mag)};
    end else begin
      k   = e - 1;
      res = '0;
    end
  endfunction

  // Hand-computed expectations that pin the model itself.
  task automatic pin_model(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic s,
                           input logic [FW-1:0] e_res, input logic e_ovf, input int e_k);
    logic [FW-1:0] r;
    logic          o;
    int            k;
    model(a, b, s, r, o, k);
    chk("model_out", 64'(r), 64'(e_res));
    chk("model_ovf", 64'(o), 64'(e_ovf));
    chk("model_k", 64'(k), 64'(e_k));
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (outstanding) begin
        cyc++;
        chk("busy_in_flight", 64'(bus_if.busy), 64'd1);
        if (bus_if.ack) begin
          chk("ack_latency", 64'(cyc), 64'(lat_q[0]));
          chk("out", 64'(bus_if.out), 64'(exp_q[0][FW-1:0]));
          chk("overflow", 64'(bus_if.overflow), 64'(exp_q[0][FW]));
          last_out = exp_q[0][FW-1:0];
          last_ovf = exp_q[0][FW];
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          outstanding = 1'b0;
        end else if (cyc >= lat_q[0]) begin
          chk("ack_timeout", 64'(cyc), 64'(lat_q[0] - 1));
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          outstanding = 1'b0;
        end
      end else begin
        chk("busy_idle", 64'(bus_if.busy), 64'd0);
        chk("ack_idle", 64'(bus_if.ack), 64'd0);
        chk("out_held", 64'(bus_if.out), 64'(last_out));
        chk("ovf_held", 64'(bus_if.overflow), 64'(last_ovf));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while ((bus_if.busy || bus_if.ack || outstanding) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 64'(n), 64'd0);
  endtask

  // Present a request and record the prediction once it is accepted.
  task automatic launch(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic s);
    logic [FW-1:0] r;
    logic          o;
    int            k;
    wait_idle();
    model(a, b, s, r, o, k);
    bus_if.a   = a;
    bus_if.b   = b;
    bus_if.sub = s;
    bus_if.req = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({o, r});
    lat_q.push_back(4 + k);
    cyc = 0;
    outstanding = 1'b1;
  endtask

  task automatic finish_op();
    int n = 0;
    while (outstanding && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) chk("finish_timeout", 64'(n), 64'd0);
  endtask

  task automatic do_op(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic s);
    launch(a, b, s);
    @(negedge clk); #1;
    bus_if.req = 1'b0;
    finish_op();
  endtask

  // req stays high through busy and the completion cycle; only one ack may result.
  task automatic held_op(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic s);
    launch(a, b, s);
    finish_op();
    @(negedge clk); #1;
    bus_if.req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rand_float(input int e_center);
    int e;
    if ($urandom_range(0, 9) == 0) e = 0;
    else if (e_center < 0) e = $urandom_range(1, 255);
    else begin
      e = e_center + $urandom_range(0, 6) - 3;
      if (e < 1) e = 1;
      if (e > 255) e = 255;
    end
    return {1'($urandom_range(0, 1)), EW'(e), MW'($urandom())};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [FW-1:0] ra, rb;
    bus_if.req = 1'b0;
    bus_if.sub = 1'b0;
    bus_if.a   = '0;
    bus_if.b   = '0;

    pin_model(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 0);
    pin_model(32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 2);
    pin_model(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1);
    pin_model(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 0);
    pin_model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 0);
    pin_model(32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 1'b0, 0);
    pin_model(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_ack", 64'(bus_if.ack), 64'd0);
    chk("rst_out", 64'(bus_if.out), 64'd0);
    chk("rst_ovf", 64'(bus_if.overflow), 64'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Directed vectors.
    do_op(32'h3F800000, 32'h3F800000, 1'b0);
    do_op(32'h3F800000, 32'h3F400000, 1'b1);
    do_op(32'h3F800000, 32'h40000000, 1'b1);
    do_op(32'h3FC00000, 32'h3FC00000, 1'b1);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    do_op(32'h3F800000, 32'h00000000, 1'b0);
    do_op(32'h4B800000, 32'h3F800000, 1'b0);
    do_op(32'h00800000, 32'h00800001, 1'b1);  // tiny difference, flushes to +0

    // req held while busy and in the completion cycle, then back-to-back.
    held_op(32'h40400000, 32'h3F800000, 1'b0);
    do_op(32'h40A00000, 32'hC0400000, 1'b0);
    do_op(32'h3F800000, 32'h3F800001, 1'b1);

    // Randomized operations; half have nearby exponents to exercise NORM.
    for (int i = 0; i < 300; i++) begin
      ra = rand_float(-1);
      if ($urandom_range(0, 1) == 1) begin
        rb = rand_float(int'(ra[FW-2 -: EW]));
        if ($urandom_range(0, 3) == 0) rb[MW-1:0] = ra[MW-1:0] ^ MW'($urandom_range(0, 7));
      end else begin
        rb = rand_float(-1);
      end
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // Reset while the 1.0-0.75 operation sits in NORM: no ack, outputs cleared.
    do_op(32'h3FC00000, 32'h3F800000, 1'b0);  // leaves a nonzero held out
    launch(32'h3F800000, 32'h3F400000, 1'b1);
    @(negedge clk); #1;
    bus_if.req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_norm_busy", 64'(bus_if.busy), 64'd0);
      chk("rst_norm_ack", 64'(bus_if.ack), 64'd0);
      chk("rst_norm_out", 64'(bus_if.out), 64'd0);
      chk("rst_norm_ovf", 64'(bus_if.overflow), 64'd0);
    end
    exp_q.delete();
    lat_q.delete();
    outstanding = 1'b0;
    last_out = '0;
    last_ovf = 1'b0;
    // rst has priority over a req on the same edge.
    bus_if.a = 32'h3F800000;
    bus_if.b = 32'h3F800000;
    bus_if.sub = 1'b0;
    bus_if.req = 1'b1;
    @(negedge clk); #1;
    chk("rst_prio_busy", 64'(bus_if.busy), 64'd0);
    bus_if.req = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    mon_en = 1'b1;
    do_op(32'h3F800000, 32'h3F400000, 1'b1);
    do_op(32'h41200000, 32'hC1100000, 1'b0);
    repeat (3) @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end
endmodule
